// File: rtl/maxpool_layer_1.sv
// 2x2 stride-2 max pooling of binary feature maps (OR per channel).
// Raster-order input, one pooled pixel per completed window.
module maxpool_layer_1 #(
    parameter int IN_W = 26,
    parameter int IN_H = 26,
    parameter int CH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [CH-1:0] conv_in,
    output logic [CH-1:0] pool_out,
    output logic          valid_out,
    output logic          frame_done
);

    localparam int OUT_W = IN_W / 2;
    localparam int OUT_H = IN_H / 2;
    localparam int N_OUT = OUT_W * OUT_H;
    localparam int CW    = $clog2(IN_W + 1);
    localparam int RW    = $clog2(IN_H + 1);
    localparam int OW    = $clog2(N_OUT + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IN_H - 1);
    localparam logic [RW-1:0] ROW_LIM   = RW'(2 * OUT_H);
    localparam logic [OW-1:0] OCNT_LAST = OW'(N_OUT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [OW-1:0] ocnt;
    logic [CH-1:0] hpair;
    logic [CH-1:0] pair;
    logic [CW-2:0] idx;
    logic          fill;
    logic          emit;

    // Sized to the index width; only the first OUT_W entries are used.
    logic [CH-1:0] lbuf [1 << (CW - 1)];

    assign idx  = col[CW-1:1];
    assign pair = hpair | conv_in;

    // An odd column is always inside the paired region, so only rows need
    // the floor check; odd rows never reach the trailing unpaired row.
    assign fill = valid_in & col[0] & ~row[0] & (row < ROW_LIM);
    assign emit = valid_in & col[0] & row[0];

    always_ff @(posedge clk) begin
        if (!rst && fill)
            lbuf[idx] <= pair;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            ocnt       <= '0;
            hpair      <= '0;
            pool_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                if (!col[0])
                    hpair <= conv_in;
                if (emit) begin
                    pool_out   <= lbuf[idx] | pair;
                    valid_out  <= 1'b1;
                    frame_done <= (ocnt == OCNT_LAST);
                    ocnt <= (ocnt == OCNT_LAST) ? '0 : ocnt + 1'b1;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_layer_1.sv
// Directed and table-driven bench for maxpool_layer_1 (26x26 and 5x5).
// Expected outputs come from hand-written tables and an OR-pool model.
module tb_maxpool_layer_1;

    logic       clk = 1'b0;
    logic       rst;
    logic       vi26, vi5;
    logic [7:0] ci26, ci5;
    logic [7:0] po26, po5;
    logic       vo26, vo5;
    logic       fd26, fd5;

    int total = 0;
    int bad   = 0;
    int stray = 0;
    int pix_cnt = 0;

    logic [7:0] fr [26][26];
    logic [7:0] exp_q [$];
    logic [7:0] got26 [$];
    logic [7:0] got5 [$];
    logic       fdq26 [$];
    logic       fdq5 [$];
    int         pc26 [$];
    logic [7:0] nogap [$];

    typedef struct {
        bit         s5;
        int         r;
        int         c;
        logic [7:0] v;
        int         idx;
    } hot_t;

    hot_t tab [9];

    maxpool_layer_1 #(.IN_W(26), .IN_H(26), .CH(8)) dut26 (
        .clk(clk), .rst(rst), .valid_in(vi26), .conv_in(ci26),
        .pool_out(po26), .valid_out(vo26), .frame_done(fd26)
    );

    maxpool_layer_1 #(.IN_W(5), .IN_H(5), .CH(8)) dut5 (
        .clk(clk), .rst(rst), .valid_in(vi5), .conv_in(ci5),
        .pool_out(po5), .valid_out(vo5), .frame_done(fd5)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vo26 === 1'b1) begin
            got26.push_back(po26);
            fdq26.push_back(fd26);
            pc26.push_back(pix_cnt);
        end else if (fd26 === 1'b1) begin
            stray++;
        end
        if (vo5 === 1'b1) begin
            got5.push_back(po5);
            fdq5.push_back(fd5);
        end else if (fd5 === 1'b1) begin
            stray++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        got26.delete();
        got5.delete();
        fdq26.delete();
        fdq5.delete();
        pc26.delete();
        exp_q.delete();
    endtask

    task automatic fill_frame(input int mode, input logic [7:0] v);
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++)
                fr[r][c] = (mode == 0) ? v : 8'($urandom);
    endtask

    // Golden model: OR of each complete 2x2 window in raster order.
    task automatic model(input int w, input int h);
        for (int r = 0; r < h / 2; r++)
            for (int c = 0; c < w / 2; c++)
                exp_q.push_back(fr[2*r][2*c] | fr[2*r][2*c+1] |
                                fr[2*r+1][2*c] | fr[2*r+1][2*c+1]);
    endtask

    task automatic drive(input bit s5, input int w, input int h,
                         input int gap, input int limit);
        int n;
        n = (w * h < limit) ? w * h : limit;
        for (int p = 0; p < n; p++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                vi26 = 1'b0;
                vi5  = 1'b0;
                ci26 = 8'($urandom);
                ci5  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            if (s5) begin
                vi5 = 1'b1;
                ci5 = fr[p / w][p % w];
            end else begin
                vi26 = 1'b1;
                ci26 = fr[p / w][p % w];
            end
            @(posedge clk);
            #1;
            pix_cnt++;
        end
        vi26 = 1'b0;
        vi5  = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input bit s5, input int per);
        int n;
        n = s5 ? got5.size() : got26.size();
        chk({nm, "_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk({nm, "_val"}, s5 ? got5[i] : got26[i], exp_q[i]);
            chk({nm, "_fd"}, s5 ? fdq5[i] : fdq26[i],
                32'((i % per) == per - 1));
        end
    endtask

    initial begin
        tab[0] = '{1'b0, 3, 5, 8'h04, 15};
        tab[1] = '{1'b0, 25, 25, 8'h81, 168};
        tab[2] = '{1'b1, 0, 0, 8'h01, 0};
        tab[3] = '{1'b1, 1, 3, 8'h80, 1};
        tab[4] = '{1'b1, 2, 1, 8'h10, 2};
        tab[5] = '{1'b1, 3, 2, 8'h22, 3};
        tab[6] = '{1'b1, 4, 0, 8'hFF, -1};
        tab[7] = '{1'b1, 0, 4, 8'hFF, -1};
        tab[8] = '{1'b1, 3, 4, 8'h0F, -1};

        rst  = 1'b1;
        vi26 = 1'b1;
        vi5  = 1'b1;
        ci26 = 8'hFF;
        ci5  = 8'hFF;
        repeat (5) begin
            @(negedge clk);
            chk("reset26", {po26, vo26, fd26}, 0);
            chk("reset5", {po5, vo5, fd5}, 0);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        vi26 = 1'b0;
        vi5  = 1'b0;
        clr();

        // Back-to-back all-ones then all-zeros frames.
        fill_frame(0, 8'hFF);
        model(26, 26);
        drive(0, 26, 26, 0, 1000);
        fill_frame(0, 8'h00);
        model(26, 26);
        drive(0, 26, 26, 0, 1000);
        settle();
        cmp("b2b", 0, 169);
        clr();

        // Single hot pixel table on both instances.
        for (int t = 0; t < 9; t++) begin
            int w;
            int n;
            w = tab[t].s5 ? 5 : 26;
            n = tab[t].s5 ? 4 : 169;
            fill_frame(0, 8'h00);
            fr[tab[t].r][tab[t].c] = tab[t].v;
            for (int i = 0; i < n; i++)
                exp_q.push_back((i == tab[t].idx) ? tab[t].v : 8'h00);
            drive(tab[t].s5, w, w, 0, 1000);
            settle();
            cmp($sformatf("hot%0d", t), tab[t].s5, n);
            clr();
        end

        // Random frame, no gaps then 50% gaps.
        fill_frame(1, 8'h00);
        model(26, 26);
        drive(0, 26, 26, 0, 1000);
        settle();
        cmp("rnd", 0, 169);
        nogap = got26;
        clr();
        model(26, 26);
        drive(0, 26, 26, 50, 1000);
        settle();
        cmp("gap", 0, 169);
        chk("gap_vs_nogap_n", got26.size(), nogap.size());
        for (int i = 0; i < got26.size() && i < nogap.size(); i++)
            chk("gap_vs_nogap", got26[i], nogap[i]);
        clr();

        // Reset after 100 pixels of a partial frame.
        fill_frame(1, 8'h00);
        drive(0, 26, 26, 0, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr();
        pix_cnt = 0;
        fill_frame(1, 8'h00);
        model(26, 26);
        drive(0, 26, 26, 0, 1000);
        settle();
        cmp("rstmid", 0, 169);
        if (pc26.size() > 0)
            chk("rstmid_first_pix", pc26[0], 28);
        else
            chk("rstmid_first_pix", 0, 28);
        clr();

        // 5x5 random frame with floor behaviour.
        fill_frame(1, 8'h00);
        model(5, 5);
        drive(1, 5, 5, 0, 1000);
        settle();
        cmp("odd5", 1, 4);
        clr();

        chk("stray_frame_done", stray, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
